// File: rtl/gen_scheduler.sv
// Generation scheduler: turns the 1 ms tick into one-cycle step_start requests,
// with run/pause, single step, selectable period, overrun flag and generation count.
module gen_scheduler #(
  parameter int BASE_MS = 25,
  parameter int MS_W    = 12,
  parameter int GEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1ms,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic [2:0]       speed,
  input  logic             step_done,
  output logic             step_start,
  output logic             running,
  output logic             overrun,
  output logic [GEN_W-1:0] gen_count
);
  typedef enum logic [1:0] {PAUSED, WAIT, FIRE, BUSY} state_t;

  state_t           state, state_n;
  logic [MS_W-1:0]  ms_cnt, ms_n, period;
  logic [MS_W:0]    ms_inc;
  logic             running_n, overrun_n;
  logic [GEN_W-1:0] gen_n;

  assign period = MS_W'(BASE_MS) << speed;
  // One extra bit so the +1 never wraps before the period compare
  assign ms_inc = {1'b0, ms_cnt} + (MS_W+1)'(1);

  always_comb begin
    state_n   = state;
    ms_n      = ms_cnt;
    running_n = running;
    overrun_n = overrun;
    gen_n     = gen_count;
    case (state)
      PAUSED: begin
        if (btn_run) begin
          running_n = 1'b1;
          ms_n      = '0;
          overrun_n = 1'b0;
          state_n   = WAIT;
        end else if (btn_step) begin
          state_n = FIRE;
        end
      end
      WAIT: begin
        if (btn_run) begin
          running_n = 1'b0;
          state_n   = PAUSED;
        end else if (tick_1ms) begin
          if (ms_inc >= {1'b0, period}) begin
            ms_n    = '0;
            state_n = FIRE;
          end else begin
            ms_n = ms_inc[MS_W-1:0];
          end
        end
      end
      FIRE: state_n = BUSY;
      BUSY: begin
        if (btn_run) running_n = 1'b0;
        // Pause lands before the tick and done handling of the same cycle
        if (running_n && tick_1ms) begin
          if (ms_inc >= {1'b0, period}) begin
            ms_n      = period;
            overrun_n = 1'b1;
          end else begin
            ms_n = ms_inc[MS_W-1:0];
          end
        end
        if (step_done) begin
          gen_n = gen_count + GEN_W'(1);
          if (!running_n) begin
            state_n = PAUSED;
          end else if (ms_n >= period) begin
            ms_n    = '0;
            state_n = FIRE;
          end else begin
            state_n = WAIT;
          end
        end
      end
      default: state_n = PAUSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PAUSED;
      ms_cnt     <= '0;
      running    <= 1'b0;
      overrun    <= 1'b0;
      gen_count  <= '0;
      step_start <= 1'b0;
    end else begin
      state      <= state_n;
      ms_cnt     <= ms_n;
      running    <= running_n;
      overrun    <= overrun_n;
      gen_count  <= gen_n;
      step_start <= (state_n == FIRE);
    end
  end
endmodule

// File: tb/tb_gen_scheduler.sv
// Bench for gen_scheduler: directed scenarios plus random traffic, all checked
// every cycle against a behavioural model of the scheduling rules.
module tb_gen_scheduler;
  localparam int BASE = 25;
  localparam int GW   = 4;

  logic          clk = 0, rst_n = 0;
  logic          tick_1ms = 0, btn_run = 0, btn_step = 0, step_done = 0;
  logic [2:0]    speed = 0;
  logic          step_start, running, overrun;
  logic [GW-1:0] gen_count;

  gen_scheduler #(.BASE_MS(BASE), .MS_W(12), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1ms(tick_1ms), .btn_run(btn_run),
    .btn_step(btn_step), .speed(speed), .step_done(step_done),
    .step_start(step_start), .running(running), .overrun(overrun),
    .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: which phase the scheduler is in and the rule outcomes
  typedef enum {M_IDLE, M_WAIT, M_FIRE, M_BUSY} mph_t;
  mph_t ph = M_IDLE;
  int   ms = 0, gen = 0;
  bit   run = 0, ovr = 0, mvalid = 0;

  always @(posedge clk) begin
    automatic mph_t p  = ph;
    automatic int   m  = ms;
    automatic int   g  = gen;
    automatic int   pr = BASE * (1 << int'(speed));
    automatic bit   r  = run;
    automatic bit   o  = ovr;
    if (!rst_n) begin
      p = M_IDLE; m = 0; g = 0; r = 0; o = 0;
    end else begin
      case (p)
        M_IDLE: if (btn_run) begin r = 1; m = 0; o = 0; p = M_WAIT; end
                else if (btn_step) p = M_FIRE;
        M_WAIT: if (btn_run) begin r = 0; p = M_IDLE; end
                else if (tick_1ms) begin
                  if (m + 1 >= pr) begin m = 0; p = M_FIRE; end
                  else m = m + 1;
                end
        M_FIRE: p = M_BUSY;
        M_BUSY: begin
          if (btn_run) r = 0;
          if (r && tick_1ms) begin
            m = (m + 1 < pr) ? m + 1 : pr;
            if (m == pr) o = 1;
          end
          if (step_done) begin
            g = (g + 1) % (1 << GW);
            if (!r) p = M_IDLE;
            else if (m >= pr) begin m = 0; p = M_FIRE; end
            else p = M_WAIT;
          end
        end
      endcase
    end
    ph  <= p; ms <= m; gen <= g; run <= r; ovr <= o;
    mvalid <= mvalid | !rst_n;
  end

  // Compare process plus tick stamps of every step_start
  int tcount = 0;
  int start_q[$];
  always @(negedge clk) begin
    if (mvalid) begin
      chk("step_start", int'(step_start), int'(ph == M_FIRE));
      chk("running",    int'(running),    int'(run));
      chk("overrun",    int'(overrun),    int'(ovr));
      chk("gen_count",  int'(gen_count),  gen);
    end
    tcount <= tcount + (tick_1ms ? 1 : 0);
    if (step_start) start_q.push_back(tcount + (tick_1ms ? 1 : 0));
  end

  // Driver: one call = one clock; also models the engine's done latency
  int tick_per = 0, eng_delay = 0, dcnt = 0, tc = 0;
  task automatic cyc(input bit r = 0, input bit s = 0, input bit d = 0);
    if (step_start && eng_delay > 0) dcnt = eng_delay;
    step_done = d;
    if (dcnt > 0) begin
      dcnt--;
      if (dcnt == 0) step_done = 1;
    end
    tick_1ms = 0;
    if (tick_per > 0) begin
      tc++;
      if (tc >= tick_per) begin tc = 0; tick_1ms = 1; end
    end
    btn_run  = r;
    btn_step = s;
    @(posedge clk); #1;
  endtask

  int base, g0;
  bit seen;

  initial begin
    rst_n = 0;
    cyc(); cyc();
    chk("rst_step_start", int'(step_start), 0);
    chk("rst_running",    int'(running), 0);
    chk("rst_overrun",    int'(overrun), 0);
    chk("rst_gen",        int'(gen_count), 0);

    rst_n = 1; tick_per = 2;
    repeat (80) cyc();
    chk("paused_no_start", start_q.size(), 0);

    // single step, extra btn_step while busy
    eng_delay = 10;
    cyc(0, 1);
    chk("step_start_next", int'(step_start), 1);
    cyc(); cyc(0, 1);
    repeat (20) cyc();
    chk("single_gen", int'(gen_count), 1);
    chk("single_starts", start_q.size(), 1);
    chk("single_paused", int'(running), 0);

    // free run, speed 0
    speed = 0; tick_per = 3; tc = 0; eng_delay = 5;
    base = start_q.size();
    cyc(1);
    repeat (320) cyc();
    chk("fr_starts", start_q.size() - base, 4);
    for (int i = base + 1; i < start_q.size(); i++)
      chk("fr_spacing25", start_q[i] - start_q[i-1], 25);
    chk("fr_gen", int'(gen_count), 5);
    chk("fr_overrun", int'(overrun), 0);

    // free run, speed 2
    cyc(1); repeat (10) cyc();
    speed = 2;
    base = start_q.size();
    cyc(1);
    repeat (640) cyc();
    chk("fr2_starts", start_q.size() - base, 2);
    if (start_q.size() - base >= 2)
      chk("fr2_spacing100", start_q[base+1] - start_q[base], 100);

    // overrun: engine withholds done
    cyc(1); repeat (10) cyc();
    chk("pause_before_ovr", int'(running), 0);
    speed = 0; eng_delay = 0; dcnt = 0;
    cyc(1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      seen = step_start;
    end
    chk("ovr_first_start", int'(seen), 1);
    repeat (90) cyc();
    chk("ovr_set", int'(overrun), 1);
    cyc(0, 0, 1);
    chk("ovr_refire", int'(step_start), 1);
    repeat (5) cyc();
    chk("ovr_sticky", int'(overrun), 1);

    // pause racing done while busy
    g0 = int'(gen_count);
    cyc(1, 0, 1);
    chk("race_running", int'(running), 0);
    chk("race_gen", int'(gen_count), (g0 + 1) % 16);
    base = start_q.size();
    repeat (300) cyc();
    chk("race_no_start", start_q.size() - base, 0);
    chk("race_ovr_kept", int'(overrun), 1);
    cyc(1);
    chk("resume_ovr_clr", int'(overrun), 0);
    cyc(1);

    // wrap after 16 single steps, then a stray done
    eng_delay = 3;
    g0 = int'(gen_count);
    repeat (16) begin cyc(0, 1); repeat (8) cyc(); end
    chk("wrap_gen", int'(gen_count), g0);
    cyc(0, 0, 1); cyc();
    chk("stray_done", int'(gen_count), g0);

    // random traffic
    tick_per = 2;
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 299) == 0) speed = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) eng_delay = $urandom_range(0, 40);
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 59) == 0);
    end
    rst_n = 1;
    repeat (4) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gen_scheduler.md
# gen_scheduler

Generation scheduler for the Game of Life core. It turns the 1 ms tick strobe into one-cycle `step_start` requests to the life-update engine. Each generation runs as a start/done handshake with the engine. The block also handles run/pause and single-step controls, a selectable generation period and a generation counter. It sits between the 1 ms timebase, the debounced button pulses and the update engine.

## Interface
Parameters:
- `BASE_MS`, 25: period in ms at `speed`=0.
- `MS_W`, 12: ms counter width; must hold `BASE_MS<<7` (3200).
- `GEN_W`, 16: generation counter width.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  synchronous reset, active-low, one clock domain.
- `tick_1ms`  in  1  one-cycle strobe, once per ms, synchronous to `clk`.
- `btn_run`  in  1  one-cycle pulse; toggles run/pause.
- `btn_step`  in  1  one-cycle pulse; single generation while paused.
- `speed`  in  3  period select: period = `BASE_MS << speed` ms.
- `step_done`  in  1  one-cycle pulse from the engine; the generation is complete.
- `step_start`  out  1  one-cycle request to the engine.
- `running`  out  1  1 = free-running mode.
- `overrun`  out  1  sticky: the engine was slower than the period.
- `gen_count`  out  `GEN_W`  completed generations, wraps.

## Operation
- States: PAUSED, WAIT, FIRE, BUSY.
- Reset (`rst_n`=0 at a clock edge): state is PAUSED. `running`, `step_start` and `overrun` are 0. `gen_count` and `ms_cnt` are 0.
- PAUSED:
  - `btn_run` sets `running`=1, clears `ms_cnt` and `overrun`, and moves to WAIT.
  - Otherwise `btn_step` moves to FIRE; `running` stays 0.
- WAIT:
  - `btn_run` sets `running`=0 and moves to PAUSED. It has priority over a same-cycle tick.
  - On `tick_1ms`: if `ms_cnt+1 >= period`, clear `ms_cnt` and move to FIRE; else increment `ms_cnt`.
  - `btn_step` is ignored.
- FIRE: `step_start`=1 for exactly this one cycle, then BUSY unconditionally.
- BUSY:
  - While `running`=1, `ms_cnt` counts ticks, saturating at `period`. Reaching `period` sets `overrun`=1.
  - `btn_run` clears `running` and does not leave BUSY.
  - On `step_done`, `gen_count` increments, wrapping all-ones to 0. Next state:
    - PAUSED if `running`=0.
    - FIRE with `ms_cnt`=0 if `ms_cnt >= period`.
    - WAIT otherwise, with `ms_cnt` retained.
  - When `btn_run` and `step_done` arrive in the same cycle, `btn_run` is applied first and the exit uses the new `running` value.
- `step_done` outside BUSY is ignored; `gen_count` is unchanged. `btn_step` in any state other than PAUSED is ignored.
- `period` is decoded combinationally from `speed` every cycle. A change takes effect at the next tick comparison. Because the comparison is `>=`, lowering the period mid-wait fires on the next tick.
- `overrun` clears only on reset or on a resume from PAUSED.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `btn_step` sampled at edge N (PAUSED): `step_start` is high in cycle N+1 only. The state is BUSY from edge N+1.
- Free-running: consecutive `step_start` pulses are `period` ticks apart, provided each `step_done` arrives before the next `period` tick.
- `step_done` at edge M: `gen_count` updates at M. The next `step_start` comes no earlier than cycle M+1 (overrun path).
- Reset mid-BUSY abandons the generation. A late `step_done` then lands in PAUSED and is ignored.

## Test plan
- Reset: after `rst_n` is low for 2 cycles, `step_start`=0, `running`=0, `overrun`=0 and `gen_count`=0. A `tick_1ms` train produces no `step_start`.
- Single step: `btn_step` pulse in PAUSED gives one `step_start` the next cycle. `step_done` 10 cycles later gives `gen_count`=1 and state PAUSED. A second `btn_step` while in BUSY gives no extra `step_start`.
- Free run at `speed`=0:
  - Setup: `btn_run`, then engine `step_done` 5 cycles after each start.
  - Required: `step_start` exactly every 25 ticks.
  - Required: `gen_count`=4 after 100 ticks, `overrun`=0.
  - `speed`=2: spacing 100 ticks.
- Overrun: `speed`=0, `step_done` withheld for 30 ticks. `overrun` rises at tick 25. On `step_done`, the next `step_start` follows in the next cycle. `overrun` stays 1 until a pause/resume.
- Pause race: `btn_run` and `step_done` in the same cycle while BUSY gives `running`=0, `gen_count`+1, state PAUSED and no further `step_start`.
- Wrap and stray done: `GEN_W`=4, 16 steps bring `gen_count` back to 0. `step_done` while PAUSED leaves `gen_count` unchanged.
